bus_driver: RTL
===============

BUS_DRIVER -- requirements
Module: bus_driver

Interface
REQ-001 Parameter WIDTH, default 16, data bus width in bits.
REQ-002 Parameter HOLD_CYCLES, default 1 (legal 1..15), cycles data_bus stays driven after the strobe.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 src0..src3  input  WIDTH each  candidate source words.
REQ-006 cmd_valid  input  1  transfer command present.
REQ-007 cmd_src  input  2  source select, 0..3 -> src0..src3.
REQ-008 cmd_dst  input  4  destination mask; bit0..bit3 -> A..D; multiple bits = broadcast.
REQ-009 cmd_ready  output  1  block accepts a command this cycle.
REQ-010 data_bus  output  WIDTH  shared bus driven toward the four-register receiver.
REQ-011 A_en, B_en, C_en, D_en  output  1 each  destination load strobes.
REQ-012 busy  output  1  transfer in progress.
REQ-013 done  output  1  one-cycle pulse when a transfer completes.
REQ-014 err  output  1  one-cycle pulse when a command with cmd_dst = 0 is rejected.

Function
REQ-015 All outputs SHALL be registered; none SHALL depend combinationally on inputs except cmd_ready.
REQ-016 FSM states SHALL be IDLE, SETUP, STROBE, HOLD.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid & cmd_ready.
REQ-018 On acceptance with cmd_dst != 0: snapshot selected src word and cmd_dst, go to SETUP.
REQ-019 SETUP (1 cycle): data_bus = snapshot, all enables 0, busy = 1; next STROBE.
REQ-020 STROBE (exactly 1 cycle): data_bus = snapshot, enables = snapshotted mask; next HOLD.
REQ-021 HOLD (HOLD_CYCLES cycles, counted by internal 4-bit counter): data_bus = snapshot, enables 0; then IDLE.
REQ-022 On the HOLD->IDLE transition, done SHALL pulse high for the first IDLE cycle.
REQ-023 In IDLE data_bus SHALL be 0, all enables 0, busy 0.
REQ-024 Source inputs changing after acceptance SHALL NOT alter data_bus for that transfer.
REQ-025 Command with cmd_dst = 0: accepted, FSM stays IDLE, err pulses the next cycle, no strobe, no done.
REQ-026 Minimum period between accepted valid commands SHALL be 3 + HOLD_CYCLES cycles; cmd_valid held high SHALL chain transfers without gaps beyond that.
REQ-027 At most one strobe SHALL occur per transfer; enables SHALL never be high outside STROBE.

Reset
REQ-028 Reset low SHALL immediately force IDLE, data_bus = 0, all enables 0, busy 0, done 0, err 0, counter 0.
REQ-029 Reset mid-transfer SHALL abort the transfer with no strobe and no done; the command is discarded.
REQ-030 After Reset release, the first rising edge SHALL accept a command if cmd_valid is high.

Structure
REQ-031 Shared package bus_pkg SHALL hold the FSM state enum, default WIDTH, NUM_DST = 4, and the HOLD counter width.
REQ-032 No sub-module; source mux, FSM, and hold counter SHALL reside in bus_driver.

Verification
REQ-033 Reset low, then cmd_valid=1, cmd_src=2, src2=16'h00A5, cmd_dst=4'b0001 -> data_bus=00A5 from cycle+1, A_en high only at cycle+2, done at cycle+4 (HOLD_CYCLES=1); receiver A = 00A5.
REQ-034 Broadcast cmd_src=0, src0=16'h1234, cmd_dst=4'b1111 -> A_en..D_en high in the same single cycle; receiver A..D all = 1234.
REQ-035 cmd_dst=0 -> cmd_ready stays 1, err pulses once, busy stays 0, no enable asserted.
REQ-036 Accept cmd_src=1 with src1=16'hBEEF, change src1 to 16'h0000 in SETUP -> data_bus and receiver keep BEEF.
REQ-037 Assert Reset low during STROBE -> enables drop to 0 asynchronously, data_bus=0, no done; next command completes normally.
REQ-038 cmd_valid held high for 3 commands with HOLD_CYCLES=2 -> acceptances exactly 5 cycles apart, three done pulses.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the bus driver: FSM state encoding, default sizes
// and the hold-counter reload helper.
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } bus_state_e;

    localparam int DEFAULT_WIDTH = 16;
    localparam int NUM_DST       = 4;
    localparam int HOLD_CNT_W    = 4;

    // The counter runs down to zero, so a hold of N cycles reloads with N-1.
    function automatic logic [HOLD_CNT_W-1:0] hold_reload(input int hold_cycles);
        return HOLD_CNT_W'(hold_cycles - 1);
    endfunction

endpackage

// File: rtl/bus_driver.sv
// Drives one selected source word onto the shared data bus and strobes the
// destination load enables (single or broadcast) with setup and hold margins.
module bus_driver
    import bus_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] src0,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [WIDTH-1:0] src3,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_src,
    input  logic [3:0]       cmd_dst,
    output logic             cmd_ready,
    output logic [WIDTH-1:0] data_bus,
    output logic             A_en,
    output logic             B_en,
    output logic             C_en,
    output logic             D_en,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = hold_reload(HOLD_CYCLES);
    localparam logic [HOLD_CNT_W-1:0] CNT_ZERO  = HOLD_CNT_W'(0);
    localparam logic [HOLD_CNT_W-1:0] CNT_ONE   = HOLD_CNT_W'(1);

    bus_state_e             state_q, state_d;
    logic [HOLD_CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]       snap_q, snap_d;
    logic [NUM_DST-1:0]     mask_q, mask_d;
    logic [WIDTH-1:0]       sel_src_s;
    logic                   accept_s;
    logic                   dst_none_s;

    logic [WIDTH-1:0]       bus_q, bus_d;
    logic [NUM_DST-1:0]     en_q, en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    assign cmd_ready  = (state_q == ST_IDLE);
    assign accept_s   = cmd_valid & cmd_ready;
    assign dst_none_s = (cmd_dst == 4'b0000);

    // Source word selection.
    always_comb begin
        sel_src_s = src0;
        case (cmd_src)
            2'd0:    sel_src_s = src0;
            2'd1:    sel_src_s = src1;
            2'd2:    sel_src_s = src2;
            2'd3:    sel_src_s = src3;
            default: sel_src_s = src0;
        endcase
    end

    // Next-state, hold counter and snapshot capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        mask_d  = mask_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && !dst_none_s) begin
                    state_d = ST_SETUP;
                    snap_d  = sel_src_s;
                    mask_d  = cmd_dst;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                state_d = ST_HOLD;
                cnt_d   = HOLD_LOAD;
            end
            ST_HOLD: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Outputs are computed from the upcoming state so they register in step with it.
    always_comb begin
        if (state_d != ST_IDLE) begin
            bus_d  = snap_d;
            busy_d = 1'b1;
        end else begin
            bus_d  = {WIDTH{1'b0}};
            busy_d = 1'b0;
        end
        if (state_d == ST_STROBE) begin
            en_d = mask_q;
        end else begin
            en_d = {NUM_DST{1'b0}};
        end
        done_d = (state_q == ST_HOLD) && (state_d == ST_IDLE);
        err_d  = accept_s && dst_none_s;
    end

    // FSM state, hold counter and transfer snapshot.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            snap_q  <= {WIDTH{1'b0}};
            mask_q  <= {NUM_DST{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            mask_q  <= mask_d;
        end
    end

    // Output registers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            bus_q  <= {WIDTH{1'b0}};
            en_q   <= {NUM_DST{1'b0}};
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            bus_q  <= bus_d;
            en_q   <= en_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign data_bus = bus_q;
    assign A_en     = en_q[0];
    assign B_en     = en_q[1];
    assign C_en     = en_q[2];
    assign D_en     = en_q[3];
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
